// File: rtl/or_stream_accumulator.sv
// or_stream_accumulator
//   Takes a stream of (a, b) vector pairs grouped into frames by up_last.
//   Each beat's bitwise OR is built from 2:1 mux cells (d0=b, d1=1, sel=a).
//   Beats are OR-accumulated across the frame. At frame end, one registered
//   result is presented on a valid/ready output. The result holds the
//   accumulated vector, a saturating beat count and a saturation flag.
//
// Ports
//   clk         clock, all state updates on posedge
//   rst         synchronous reset, active-low
//   up_valid    upstream beat valid
//   up_ready    beat can be accepted this cycle (combinational from down_ready)
//   up_a/up_b   operands, WIDTH bits
//   up_last     final beat of the frame
//   down_valid  result register holds an unconsumed result
//   down_ready  downstream accepts the result
//   down_data   OR of every a and b in the frame
//   down_count  beats in the frame, saturating at 2^CNT_W-1
//   down_sat    frame had more than 2^CNT_W-1 beats
//   down_any    reduction OR of down_data
//
// Output register states
//   state | meaning
//   EMPTY | no result pending, down_valid=0
//   FULL  | result pending, down_valid=1

module or_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module or_stream_accumulator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic             up_last,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic [CNT_W-1:0] down_count,
  output logic             down_sat,
  output logic             down_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] beat;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] cnt1;
  logic             accept;
  logic             load;

  // Per-bit OR: a=1 selects the constant 1, otherwise b passes through.
  for (genvar i = 0; i < WIDTH; i++) begin : g_or
    or_mux2 u_mux (
      .d0  (up_b[i]),
      .d1  (1'b1),
      .sel (up_a[i]),
      .y   (beat[i])
    );
  end

  assign sum  = acc | beat;
  assign cnt1 = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // Ready depends on down_ready combinationally so that a drain and a new
  // last-beat load can share a cycle, giving one result per cycle.
  assign up_ready   = (state == EMPTY) || down_ready;
  assign accept     = up_valid && up_ready;
  assign load       = accept && up_last;
  assign down_valid = (state == FULL);
  assign down_any   = |down_data;

  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load)                             state_next = FULL;
    else if (state == FULL && down_ready) state_next = EMPTY;
  end

  // Result fields are left as-is on drain; only down_valid falls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc        <= '0;
      cnt        <= '0;
      down_data  <= '0;
      down_count <= '0;
      down_sat   <= 1'b0;
    end else if (accept) begin
      if (up_last) begin
        down_data  <= sum;
        down_count <= cnt1;
        down_sat   <= (cnt == CNT_MAX);
        acc        <= '0;
        cnt        <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt1;
      end
    end
  end

endmodule

// File: tb/tb_or_stream_accumulator.sv
// tb_or_stream_accumulator
//   Directed bench for or_stream_accumulator with hand-computed expectations.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_or_stream_accumulator;

  logic       clk;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_a;
  logic [7:0] up_b;
  logic       up_last;
  logic       down_valid;
  logic       down_ready;
  logic [7:0] down_data;
  logic [3:0] down_count;
  logic       down_sat;
  logic       down_any;

  int checks = 0;
  int errors = 0;

  or_stream_accumulator #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_a       (up_a),
    .up_b       (up_b),
    .up_last    (up_last),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_count (down_count),
    .down_sat   (down_sat),
    .down_any   (down_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    up_valid = 1'b1;
    up_a     = a;
    up_b     = b;
    up_last  = last;
    #0;
    check("beat_ready", 32'(up_ready), 1);
    step();
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] data,
                              input logic [3:0] count, input logic sat);
    check({tag, "_valid"}, 32'(down_valid), 1);
    check({tag, "_data"},  32'(down_data),  32'(data));
    check({tag, "_count"}, 32'(down_count), 32'(count));
    check({tag, "_sat"},   32'(down_sat),   32'(sat));
  endtask

  initial begin
    rst        = 1'b0;
    up_valid   = 1'b1;
    up_last    = 1'b1;
    up_a       = 8'hFF;
    up_b       = 8'h00;
    down_ready = 1'b1;

    // Reset held two cycles with a last beat offered
    step();
    step();
    check("rst_valid", 32'(down_valid), 0);
    check("rst_data",  32'(down_data),  0);
    check("rst_count", 32'(down_count), 0);
    check("rst_sat",   32'(down_sat),   0);
    up_valid = 1'b0;
    up_last  = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_ready", 32'(up_ready), 1);

    // Multi-beat frame: 01 | 10 | 04 | 80 = 95
    send_beat(8'h01, 8'h00, 1'b0);
    check("mb_no_early_valid", 32'(down_valid), 0);
    send_beat(8'h00, 8'h10, 1'b0);
    send_beat(8'h04, 8'h80, 1'b1);
    check_result("mb", 8'h95, 4'd3, 1'b0);
    check("mb_any", 32'(down_any), 1);
    step();
    check("mb_drain_valid", 32'(down_valid), 0);
    check("mb_drain_hold",  32'(down_data),  'h95);

    // Single zero beat
    send_beat(8'h00, 8'h00, 1'b1);
    check_result("zero", 8'h00, 4'd1, 1'b0);
    check("zero_any", 32'(down_any), 0);
    step();

    // Backpressure: pending result 33, next frame offered while stalled
    down_ready = 1'b0;
    send_beat(8'h33, 8'h00, 1'b1);
    check_result("bp_first", 8'h33, 4'd1, 1'b0);
    up_valid = 1'b1;
    up_a     = 8'h0F;
    up_b     = 8'h00;
    up_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #0;
      check("bp_stall_ready", 32'(up_ready), 0);
      step();
      check_result("bp_hold", 8'h33, 4'd1, 1'b0);
    end
    down_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(up_ready), 1);
    step();
    up_valid = 1'b0;
    up_last  = 1'b0;
    check_result("bp_new", 8'h0F, 4'd1, 1'b0);
    step();
    check("bp_drain_valid", 32'(down_valid), 0);

    // Exactly 15 beats: count reaches max without saturating
    for (int i = 0; i < 14; i++) send_beat(8'h00, 8'h00, 1'b0);
    send_beat(8'h00, 8'h00, 1'b1);
    check_result("len15", 8'h00, 4'd15, 1'b0);

    // 20 beats: saturates
    for (int i = 0; i < 19; i++) send_beat(8'h00, 8'h00, 1'b0);
    send_beat(8'h00, 8'h00, 1'b1);
    check_result("sat20", 8'h00, 4'd15, 1'b1);

    // Following 2-beat frame clears saturation
    send_beat(8'h20, 8'h00, 1'b0);
    send_beat(8'h00, 8'h02, 1'b1);
    check_result("after_sat", 8'h22, 4'd2, 1'b0);

    // Back-to-back single-beat frames, one result per cycle
    send_beat(8'h01, 8'h00, 1'b1);
    check_result("b2b_0", 8'h01, 4'd1, 1'b0);
    send_beat(8'h02, 8'h00, 1'b1);
    check_result("b2b_1", 8'h02, 4'd1, 1'b0);
    send_beat(8'h40, 8'h04, 1'b1);
    check_result("b2b_2", 8'h44, 4'd1, 1'b0);
    step();
    check("b2b_drain_valid", 32'(down_valid), 0);

    // Reset mid-frame discards the partial accumulation
    send_beat(8'h0F, 8'h0F, 1'b0);
    send_beat(8'h0F, 8'h0F, 1'b0);
    rst      = 1'b0;
    up_valid = 1'b1;
    up_a     = 8'hFF;
    up_b     = 8'h00;
    up_last  = 1'b0;
    step();
    up_valid = 1'b0;
    rst      = 1'b1;
    check("midrst_valid", 32'(down_valid), 0);
    send_beat(8'h10, 8'h00, 1'b1);
    check_result("midrst", 8'h10, 4'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
